// File: rtl/riscv_pkg.sv
// Shared fetch-path types: machine width, queue entry layout and fetch modes.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        MODE_RUN   = 1'b0,
        MODE_DRAIN = 1'b1
    } fetch_mode_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous power-of-two FIFO of fetch entries with flush.
// The head entry is read straight from storage flops and forced to zero when empty.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush,
    input  logic                       push,
    input  fetch_entry_t               wdata,
    input  logic                       pop,
    output fetch_entry_t               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign do_push = push && !flush && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited imem requests, in-order response
// capture into a prefetch queue, and redirect handling that drops stale responses.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter int              XLEN     = riscv_pkg::XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_addr_o,
    input  logic            rsp_valid_i,
    input  logic [XLEN-1:0] rsp_data_i,
    output logic            instr_valid_o,
    output logic [XLEN-1:0] instr_o,
    output logic [XLEN-1:0] pc_o,
    input  logic            instr_ready_i
);

    localparam int CW = $clog2(DEPTH+1);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    fetch_mode_t     mode_q, mode_d;
    logic [CW-1:0]   q_count;
    logic            q_full;
    logic            q_empty;
    logic            req_xfer;
    logic            push;
    logic            pop;
    logic [XLEN-1:0] redirect_pc_al;
    fetch_entry_t    push_entry;
    fetch_entry_t    head;

    // Every response in flight already owns a queue slot, so rsp_valid_i never stalls.
    assign req_valid_o    = !rst_i && !q_full
                            && (({1'b0, q_count} + {1'b0, outstanding_q}) < (CW+1)'(DEPTH));
    assign req_addr_o     = fetch_pc_q;
    assign req_xfer       = req_valid_o && req_ready_i;
    assign redirect_pc_al = redirect_pc_i & ~XLEN'(3);

    assign push             = rsp_valid_i && (mode_q == MODE_RUN) && !redirect_valid_i;
    assign pop              = instr_valid_o && instr_ready_i && !redirect_valid_i;
    assign push_entry.pc    = rsp_pc_q;
    assign push_entry.instr = rsp_data_i;

    assign instr_valid_o = !q_empty;
    assign instr_o       = head.instr;
    assign pc_o          = head.pc;

    always_comb begin
        outstanding_d = outstanding_q + CW'(req_xfer) - CW'(rsp_valid_i);
        fetch_pc_d    = req_xfer ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        rsp_pc_d      = push ? rsp_pc_q + XLEN'(4) : rsp_pc_q;
        drop_d        = drop_q;
        mode_d        = mode_q;

        if (mode_q == MODE_DRAIN && rsp_valid_i) begin
            drop_d = drop_q - 1'b1;
            if (drop_q == CW'(1)) mode_d = MODE_RUN;
        end

        // Everything still in flight after this cycle belongs to the old stream.
        if (redirect_valid_i) begin
            fetch_pc_d = redirect_pc_al;
            rsp_pc_d   = redirect_pc_al;
            drop_d     = outstanding_d;
            mode_d     = (outstanding_d != '0) ? MODE_DRAIN : MODE_RUN;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            mode_q        <= MODE_RUN;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            mode_q        <= mode_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .flush (redirect_valid_i),
        .push  (push),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

endmodule
